// File: rtl/stripe_pkg.sv
// ---------------------------------------------------------------------------
// stripe_pkg
//   Definitions shared between the operand broadcaster and the stripe/PE side
//   of the operand bus.
//   - BLOCK_WIDTH : operand block width (8 lanes x 16 bit)
//   - TAG_WIDTH   : width of tags, strides, beat counts and memory addresses
//   - INSTR_WIDTH : PE instruction width
//   - bc_state_t  : operand broadcaster sequencing states
// ---------------------------------------------------------------------------
package stripe_pkg;

    localparam int BLOCK_WIDTH = 128;
    localparam int TAG_WIDTH   = 12;
    localparam int INSTR_WIDTH = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,  // waiting for a command
        ST_CFG  = 3'd1,  // configuration beat on the bus
        ST_RDA  = 3'd2,  // read block at curA
        ST_RDB  = 3'd3,  // read block at curB, capture d0
        ST_CAPB = 3'd4,  // capture d1
        ST_SEND = 3'd5,  // data beat on the bus
        ST_DONE = 3'd6   // completion pulse
    } bc_state_t;

endpackage : stripe_pkg

// File: rtl/tag_stepper.sv
// ---------------------------------------------------------------------------
// tag_stepper
//   One tag register of the broadcaster: loads a base tag, advances by a
//   stride, or holds. Addition wraps modulo 2^W.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset (tag clears to 0)
//     load   : load base (has priority over step)
//     base   : base tag
//     step   : add stride to the current tag
//     stride : stride
//     tag    : current tag
// ---------------------------------------------------------------------------
module tag_stepper #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] base,
    input  logic         step,
    input  logic [W-1:0] stride,
    output logic [W-1:0] tag
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
        end else if (load) begin
            tag <= base;
        end else if (step) begin
            tag <= tag + stride;
        end
    end

endmodule : tag_stepper

// File: rtl/operand_broadcaster.sv
// ---------------------------------------------------------------------------
// operand_broadcaster
//   Transmit end of the stripe operand bus. Accepts one command, emits a
//   configuration beat (base tags, strides, iteration limit, instruction),
//   then for each iteration reads two blocks from block memory and emits a
//   (tagA, d0) / (tagB, d1) data beat, stepping both tags by their strides.
//   Ports:
//     clk, rst                  : clock; asynchronous active-low reset
//     cmd_valid/cmd_ready       : command handshake
//     cmd_tagA/B, cmd_strideA/B : base tags and strides
//     cmd_count, cmd_instr      : beat count, PE instruction
//     cmd_abort                 : abort the active command (no done)
//     mem_rd_en/mem_addr        : block memory read, data one cycle later
//     mem_rd_data               : block memory read data
//     cfg_valid/cfg_ready       : configuration beat handshake
//     strideA_OUT, strideB_OUT,
//     iter_lim_OUT, instr_OUT   : configuration payload
//     bus_valid/bus_ready       : data beat handshake
//     tagA_OUT, tagB_OUT        : tags (base tags during the cfg beat)
//     d0_OUT, d1_OUT            : operand blocks
//     done                      : one-cycle completion pulse
// ---------------------------------------------------------------------------
module operand_broadcaster #(
    parameter int BLOCK_WIDTH = stripe_pkg::BLOCK_WIDTH,
    parameter int TAG_WIDTH   = stripe_pkg::TAG_WIDTH,
    parameter int INSTR_WIDTH = stripe_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    // command
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [TAG_WIDTH-1:0]   cmd_tagA,
    input  logic [TAG_WIDTH-1:0]   cmd_tagB,
    input  logic [TAG_WIDTH-1:0]   cmd_strideA,
    input  logic [TAG_WIDTH-1:0]   cmd_strideB,
    input  logic [TAG_WIDTH-1:0]   cmd_count,
    input  logic [INSTR_WIDTH-1:0] cmd_instr,
    input  logic                   cmd_abort,
    // block memory
    output logic                   mem_rd_en,
    output logic [TAG_WIDTH-1:0]   mem_addr,
    input  logic [BLOCK_WIDTH-1:0] mem_rd_data,
    // configuration beat
    output logic                   cfg_valid,
    input  logic                   cfg_ready,
    output logic [TAG_WIDTH-1:0]   strideA_OUT,
    output logic [TAG_WIDTH-1:0]   strideB_OUT,
    output logic [TAG_WIDTH-1:0]   iter_lim_OUT,
    output logic [INSTR_WIDTH-1:0] instr_OUT,
    // data beat
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [TAG_WIDTH-1:0]   tagA_OUT,
    output logic [TAG_WIDTH-1:0]   tagB_OUT,
    output logic [BLOCK_WIDTH-1:0] d0_OUT,
    output logic [BLOCK_WIDTH-1:0] d1_OUT,
    output logic                   done
);

    import stripe_pkg::*;

    bc_state_t state, state_nxt;

    logic [TAG_WIDTH-1:0]   stride_a_q, stride_b_q, count_q, iter_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [BLOCK_WIDTH-1:0] d0_q, d1_q;
    logic [TAG_WIDTH-1:0]   cur_a, cur_b;

    logic accept;     // command taken this cycle
    logic beat_take;  // data beat taken this cycle (abort cancels it)
    logic last_beat;  // the beat on the bus is the final one
    logic abort_act;  // abort applies only outside IDLE

    assign abort_act = cmd_abort && (state != ST_IDLE);
    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign beat_take = (state == ST_SEND) && bus_ready && !abort_act;
    assign last_beat = (TAG_WIDTH'(iter_q + 1'b1) == count_q);

    // ---------------------------------------------------------------------
    // tag registers: loaded with the base tags on accept, which is also
    // what the cfg beat shows, then stepped once per taken data beat
    // ---------------------------------------------------------------------
    tag_stepper #(.W(TAG_WIDTH)) u_step_a (
        .clk    (clk),
        .rst_n  (rst),
        .load   (accept),
        .base   (cmd_tagA),
        .step   (beat_take),
        .stride (stride_a_q),
        .tag    (cur_a)
    );

    tag_stepper #(.W(TAG_WIDTH)) u_step_b (
        .clk    (clk),
        .rst_n  (rst),
        .load   (accept),
        .base   (cmd_tagB),
        .step   (beat_take),
        .stride (stride_b_q),
        .tag    (cur_b)
    );

    // ---------------------------------------------------------------------
    // state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_nxt = ST_CFG;
            ST_CFG:  if (cfg_ready) state_nxt = (count_q == '0) ? ST_DONE : ST_RDA;
            ST_RDA:  state_nxt = ST_RDB;
            ST_RDB:  state_nxt = ST_CAPB;
            ST_CAPB: state_nxt = ST_SEND;
            ST_SEND: if (bus_ready) state_nxt = last_beat ? ST_DONE : ST_RDA;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // abort overrides any same-cycle handshake
        if (abort_act) state_nxt = ST_IDLE;
    end

    // ---------------------------------------------------------------------
    // command fields, iteration counter, block capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stride_a_q <= '0;
            stride_b_q <= '0;
            count_q    <= '0;
            instr_q    <= '0;
            iter_q     <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
        end else begin
            if (accept) begin
                stride_a_q <= cmd_strideA;
                stride_b_q <= cmd_strideB;
                count_q    <= cmd_count;
                instr_q    <= cmd_instr;
                iter_q     <= '0;
            end else if (beat_take) begin
                iter_q <= iter_q + 1'b1;
            end
            // read issued in RDA returns during RDB, read from RDB during CAPB
            if (state == ST_RDB)  d0_q <= mem_rd_data;
            if (state == ST_CAPB) d1_q <= mem_rd_data;
        end
    end

    // ---------------------------------------------------------------------
    // outputs: decoded from registered state or taken straight from
    // registers, so ready inputs never reach the payload
    // ---------------------------------------------------------------------
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        cfg_valid = (state == ST_CFG);
        bus_valid = (state == ST_SEND);
        done      = (state == ST_DONE);
        mem_rd_en = (state == ST_RDA) || (state == ST_RDB);
        mem_addr  = '0;
        if (state == ST_RDA) mem_addr = cur_a;
        if (state == ST_RDB) mem_addr = cur_b;
    end

    assign strideA_OUT  = stride_a_q;
    assign strideB_OUT  = stride_b_q;
    assign iter_lim_OUT = count_q;
    assign instr_OUT    = instr_q;
    assign tagA_OUT     = cur_a;
    assign tagB_OUT     = cur_b;
    assign d0_OUT       = d0_q;
    assign d1_OUT       = d1_q;

endmodule : operand_broadcaster

// File: tb/tb_operand_broadcaster.sv
module tb_operand_broadcaster;

    localparam int BW = 128;
    localparam int TW = 12;
    localparam int IW = 7;

    typedef logic [279:0] cv_t;

    typedef struct packed {
        logic [TW-1:0] ta, tb, sa, sb, cnt;
        logic [IW-1:0] ins;
    } cfg_t;

    typedef struct packed {
        logic [TW-1:0] ta, tb;
        logic [BW-1:0] d0, d1;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0, cmd_abort = 1'b0;
    logic          cmd_ready;
    logic [TW-1:0] cmd_tagA = '0, cmd_tagB = '0, cmd_strideA = '0, cmd_strideB = '0, cmd_count = '0;
    logic [IW-1:0] cmd_instr = '0;
    logic          mem_rd_en;
    logic [TW-1:0] mem_addr;
    logic [BW-1:0] mem_rd_data = '0;
    logic          cfg_valid, cfg_ready = 1'b1;
    logic [TW-1:0] strideA_OUT, strideB_OUT, iter_lim_OUT;
    logic [IW-1:0] instr_OUT;
    logic          bus_valid, bus_ready = 1'b1;
    logic [TW-1:0] tagA_OUT, tagB_OUT;
    logic [BW-1:0] d0_OUT, d1_OUT;
    logic          done;

    operand_broadcaster dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tagA(cmd_tagA), .cmd_tagB(cmd_tagB),
        .cmd_strideA(cmd_strideA), .cmd_strideB(cmd_strideB),
        .cmd_count(cmd_count), .cmd_instr(cmd_instr), .cmd_abort(cmd_abort),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .strideA_OUT(strideA_OUT), .strideB_OUT(strideB_OUT),
        .iter_lim_OUT(iter_lim_OUT), .instr_OUT(instr_OUT),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .tagA_OUT(tagA_OUT), .tagB_OUT(tagB_OUT),
        .d0_OUT(d0_OUT), .d1_OUT(d1_OUT),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input cv_t act, input cv_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // block memory contents: distinct, address-derived pattern
    function automatic logic [BW-1:0] blk(input logic [TW-1:0] a);
        return {{7{{4'hC, a}}}, 4'h3, a};
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= blk(mem_addr);

    // ---------------- behavioural model / scoreboard ----------------
    cfg_t          exp_cfg[$];
    beat_t         exp_beat[$];
    logic [23:0]   taken[$];
    int            n_done = 0, done_cyc = 0, cfg_hs_cyc = 0, n_reads = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (cfg_valid) begin
                if (exp_cfg.size() == 0) check("cfg_unexpected", cv_t'(cfg_valid), cv_t'(0));
                else begin
                    check("cfg_beat", cv_t'({tagA_OUT, tagB_OUT, strideA_OUT, strideB_OUT,
                                             iter_lim_OUT, instr_OUT}), cv_t'(exp_cfg[0]));
                    if (cfg_ready && !cmd_abort) begin
                        exp_cfg.delete(0);
                        cfg_hs_cyc = cyc;
                    end
                end
            end
            if (bus_valid) begin
                if (exp_beat.size() == 0) check("beat_unexpected", cv_t'(bus_valid), cv_t'(0));
                else begin
                    check("data_beat", cv_t'({tagA_OUT, tagB_OUT, d0_OUT, d1_OUT}), cv_t'(exp_beat[0]));
                    if (bus_ready && !cmd_abort) begin
                        exp_beat.delete(0);
                        taken.push_back({tagA_OUT, tagB_OUT});
                    end
                end
            end
            check("valid_excl", cv_t'(cfg_valid & bus_valid), cv_t'(0));
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (mem_rd_en) n_reads++;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [TW-1:0] ta, input logic [TW-1:0] sa,
                         input logic [TW-1:0] tb, input logic [TW-1:0] sb,
                         input logic [TW-1:0] cnt, input logic [IW-1:0] ins,
                         output int acc);
        int t;
        exp_cfg.push_back('{ta: ta, tb: tb, sa: sa, sb: sb, cnt: cnt, ins: ins});
        for (int i = 0; i < int'(cnt); i++) begin
            logic [TW-1:0] a, b;
            a = TW'(int'(ta) + i * int'(sa));
            b = TW'(int'(tb) + i * int'(sb));
            exp_beat.push_back('{ta: a, tb: b, d0: blk(a), d1: blk(b)});
        end
        cmd_tagA = ta; cmd_strideA = sa; cmd_tagB = tb; cmd_strideB = sb;
        cmd_count = cnt; cmd_instr = ins; cmd_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > 50) begin
                check("accept_timeout", cv_t'(cmd_ready), cv_t'(1));
                break;
            end
        end
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d_before);
        int t = 0;
        while (n_done == d_before && t < 300) begin
            tick();
            t++;
        end
        check("done_timeout", cv_t'(n_done != d_before), cv_t'(1));
    endtask

    task automatic wait_taken(input int n);
        int t = 0;
        while (taken.size() < n && t < 300) begin
            tick();
            t++;
        end
        check("taken_timeout", cv_t'(taken.size()), cv_t'(n));
    endtask

    task automatic wait_bus_valid();
        int t = 0;
        while (!bus_valid && t < 300) begin
            tick();
            t++;
        end
        check("bus_valid_timeout", cv_t'(bus_valid), cv_t'(1));
    endtask

    task automatic basic_run(input string tag);
        int acc, d;
        d = n_done;
        taken.delete();
        issue(12'h010, 12'h001, 12'h100, 12'h010, 12'd3, 7'h15, acc);
        wait_done(d);
        check({tag, "_latency"}, cv_t'(done_cyc - acc), cv_t'(14));
        check({tag, "_nbeats"}, cv_t'(taken.size()), cv_t'(3));
        if (taken.size() == 3) begin
            check({tag, "_b0"}, cv_t'(taken[0]), cv_t'(24'h010100));
            check({tag, "_b1"}, cv_t'(taken[1]), cv_t'(24'h011110));
            check({tag, "_b2"}, cv_t'(taken[2]), cv_t'(24'h012120));
        end
        tick(); tick();
        check({tag, "_one_done"}, cv_t'(n_done - d), cv_t'(1));
        check({tag, "_idle"}, cv_t'(cmd_ready), cv_t'(1));
        check({tag, "_leftover"}, cv_t'(exp_beat.size() + exp_cfg.size()), cv_t'(0));
    endtask

    initial begin
        int acc, d, r;
        // ---- reset state ----
        tick(); tick();
        check("rst_cmd_ready", cv_t'(cmd_ready), cv_t'(1));
        check("rst_valids", cv_t'({cfg_valid, bus_valid, mem_rd_en, done}), cv_t'(0));
        check("rst_payload", cv_t'({tagA_OUT, tagB_OUT, iter_lim_OUT, d0_OUT}), cv_t'(0));
        rst = 1'b1;
        tick();

        // ---- basic run ----
        basic_run("basic");

        // ---- backpressure during beat 2 ----
        d = n_done; r = n_reads; taken.delete();
        issue(12'h200, 12'h003, 12'h300, 12'h007, 12'd3, 7'h01, acc);
        wait_taken(1);
        bus_ready = 1'b0;
        wait_bus_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_tags", cv_t'({tagA_OUT, tagB_OUT}), cv_t'(24'h203307));
            check("bp_hold_data", cv_t'({d0_OUT, d1_OUT}), cv_t'({blk(12'h203), blk(12'h307)}));
            tick();
        end
        bus_ready = 1'b1;
        wait_done(d);
        check("bp_nbeats", cv_t'(taken.size()), cv_t'(3));
        if (taken.size() == 3) check("bp_b1", cv_t'(taken[1]), cv_t'(24'h203307));
        check("bp_reads", cv_t'(n_reads - r), cv_t'(6));
        check("bp_latency", cv_t'(done_cyc - acc), cv_t'(19));

        // ---- tag wrap ----
        d = n_done; taken.delete();
        issue(12'hFFF, 12'h002, 12'h000, 12'h005, 12'd2, 7'h22, acc);
        wait_done(d);
        check("wrap_nbeats", cv_t'(taken.size()), cv_t'(2));
        if (taken.size() == 2) begin
            check("wrap_b0", cv_t'(taken[0]), cv_t'(24'hFFF000));
            check("wrap_b1", cv_t'(taken[1]), cv_t'(24'h001005));
        end

        // ---- zero count ----
        tick();
        d = n_done; r = n_reads; taken.delete();
        issue(12'h123, 12'h001, 12'h456, 12'h001, 12'd0, 7'h33, acc);
        wait_done(d);
        check("zero_done_lat", cv_t'(done_cyc - cfg_hs_cyc), cv_t'(1));
        check("zero_nbeats", cv_t'(taken.size()), cv_t'(0));
        check("zero_reads", cv_t'(n_reads - r), cv_t'(0));

        // ---- abort with beat 1 handshake ----
        tick();
        d = n_done; taken.delete();
        issue(12'h040, 12'h001, 12'h080, 12'h001, 12'd4, 7'h44, acc);
        wait_bus_valid();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("abort_idle", cv_t'(cmd_ready), cv_t'(1));
        check("abort_valids", cv_t'({cfg_valid, bus_valid, mem_rd_en, done}), cv_t'(0));
        check("abort_not_taken", cv_t'(taken.size()), cv_t'(0));
        exp_beat.delete();
        exp_cfg.delete();
        issue(12'h050, 12'h002, 12'h060, 12'h003, 12'd2, 7'h55, acc);
        wait_done(d);
        check("abort_one_done", cv_t'(n_done - d), cv_t'(1));
        check("abort_new_lat", cv_t'(done_cyc - acc), cv_t'(10));
        if (taken.size() == 2) begin
            check("abort_new_b0", cv_t'(taken[0]), cv_t'(24'h050060));
            check("abort_new_b1", cv_t'(taken[1]), cv_t'(24'h052063));
        end else check("abort_new_nbeats", cv_t'(taken.size()), cv_t'(2));

        // ---- reset mid-run, during RDB of beat 2 ----
        tick();
        d = n_done; taken.delete();
        issue(12'h010, 12'h001, 12'h100, 12'h010, 12'd3, 7'h15, acc);
        wait_taken(1);   // now in RDA of beat 2
        tick();          // RDB
        check("mr_in_rdb", cv_t'({mem_rd_en, mem_addr}), cv_t'({1'b1, 12'h110}));
        #1 rst = 1'b0;
        #1;
        check("mr_cmd_ready", cv_t'(cmd_ready), cv_t'(1));
        check("mr_valids", cv_t'({cfg_valid, bus_valid, mem_rd_en, done}), cv_t'(0));
        check("mr_payload", cv_t'({tagA_OUT, tagB_OUT, strideA_OUT, iter_lim_OUT, d0_OUT}), cv_t'(0));
        exp_beat.delete();
        exp_cfg.delete();
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        check("mr_stay_idle", cv_t'({cmd_ready, cfg_valid, bus_valid}), cv_t'(3'b100));
        check("mr_no_done", cv_t'(n_done - d), cv_t'(0));
        basic_run("rerun");

        // ---- aliased tags ----
        d = n_done; r = n_reads; taken.delete();
        issue(12'h020, 12'h001, 12'h020, 12'h001, 12'd2, 7'h66, acc);
        wait_done(d);
        check("alias_reads", cv_t'(n_reads - r), cv_t'(4));
        if (taken.size() == 2) begin
            check("alias_b0", cv_t'(taken[0]), cv_t'(24'h020020));
            check("alias_b1", cv_t'(taken[1]), cv_t'(24'h021021));
        end else check("alias_nbeats", cv_t'(taken.size()), cv_t'(2));

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_operand_broadcaster

// File: doc/operand_broadcaster.md
# operand_broadcaster

Transmit end of the stripe operand bus. It takes one command from the sequencer and sends a configuration beat (tags, strides, iteration limit, instruction) down the stripe chain. It then reads operand blocks from block memory and broadcasts a sequence of tagged (tagA, d0) / (tagB, d1) beats, advancing both tags by their strides until the iteration count is exhausted. It sits between the sequencer/block memory and the first stripe's tag/data inputs.

## Interface
- BLOCK_WIDTH, 128: operand block width (8 × 16-bit lanes).
- TAG_WIDTH, 12: tag, stride, count and memory address width.
- INSTR_WIDTH, 7: PE instruction width.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_tagA, cmd_tagB, cmd_strideA, cmd_strideB, cmd_count  in  TAG_WIDTH  base tags, strides, beat count.
- cmd_instr  in  INSTR_WIDTH  instruction forwarded to stripes.
- cmd_abort  in  1  synchronous abort of the active command.
- mem_rd_en  out  1  block memory read strobe.
- mem_addr  out  TAG_WIDTH  read address (= tag).
- mem_rd_data  in  BLOCK_WIDTH  read data, valid 1 cycle after mem_rd_en.
- cfg_valid / cfg_ready  out/in  1  configuration beat handshake.
- strideA_OUT, strideB_OUT, iter_lim_OUT  out  TAG_WIDTH  configuration payload.
- instr_OUT  out  INSTR_WIDTH  configuration payload.
- bus_valid / bus_ready  out/in  1  data beat handshake.
- tagA_OUT, tagB_OUT  out  TAG_WIDTH  tags; they carry base tags during the cfg beat.
- d0_OUT, d1_OUT  out  BLOCK_WIDTH  operand blocks.
- done  out  1  one-cycle pulse when a command completes (not on abort).

## Operation
- States: IDLE, CFG, RDA, RDB, CAPB, SEND, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch all cmd_* fields, clear the iteration counter, and go to CFG.
- CFG:
  - cfg_valid=1 with tagA_OUT/tagB_OUT = base tags, strides, iter_lim_OUT=cmd_count, instr_OUT.
  - On cfg_ready, go to RDA; if cmd_count==0, go to DONE instead.
- RDA: mem_rd_en=1, mem_addr=curA. Then go to RDB.
- RDB: mem_rd_en=1, mem_addr=curB. Register mem_rd_data into d0. Then go to CAPB.
- CAPB: register mem_rd_data into d1. Then go to SEND.
- SEND:
  - bus_valid=1; tagA_OUT=curA, tagB_OUT=curB, d0_OUT/d1_OUT held stable.
  - On bus_ready: curA+=strideA, curB+=strideB (mod 2^TAG_WIDTH, wrap silently), iter+=1.
  - If iter+1==cmd_count, go to DONE; else go to RDA.
- DONE: done=1 for one cycle, then go to IDLE.
- tagA==tagB is legal: both reads are issued and d0 equals d1.
- cmd_abort (any non-IDLE state) returns to IDLE next cycle. It drops valids and memory strobes, and no done is generated. Abort wins over a same-cycle bus_ready or cfg_ready: that beat counts as not taken.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset asserted mid-operation forces IDLE immediately. Every register clears to 0, all outputs are 0 except cmd_ready=1. The partial beat is lost.

## Timing
- Valids and payloads are registered or decoded from registered state; no combinational path from bus_ready/cfg_ready to the payload.
- Payload holds stable while valid=1 and ready=0.
- Command accept to cfg_valid: 1 cycle.
- cfg handshake to first bus_valid: 3 cycles (RDA, RDB, CAPB).
- Beat-to-beat with bus_ready tied 1: 4 cycles (SEND + 3 read cycles).
- Last bus handshake to done: 1 cycle. done to cmd_ready: 1 cycle.
- Total for N beats with no backpressure: 1 (CFG) + 4N + 1 (DONE) cycles after accept.

## Structure
- Shared package stripe_pkg holds:
  - BLOCK_WIDTH, TAG_WIDTH, INSTR_WIDTH defaults (shared with the stripe/PE side).
  - the broadcaster state enum.
- Sub-module tag_stepper (load-base / add-stride / hold tag register, asynchronous active-low reset), instantiated twice: one for A, one for B.
- FSM, counter and data capture live in the top module.

## Test plan
- Basic run: cmd tagA=0x010, strideA=1, tagB=0x100, strideB=0x010, count=3, bus_ready=1.
  - Expect cfg beat with tags 0x010/0x100 and iter_lim=3.
  - Then 3 beats: (0x010,0x100), (0x011,0x110), (0x012,0x120), d0/d1 equal the memory contents at those addresses.
  - One done pulse; total 14 cycles after accept.
- Backpressure: bus_ready low 5 cycles during beat 2.
  - Beat 2 tags/data are held unchanged for all 5 cycles and no tag advances.
  - All 3 beats are delivered exactly once.
- Wrap and zero count:
  - tagA=0xFFF, strideA=2, count=2 → beat tags 0xFFF then 0x001.
  - A separate command with count=0 → cfg beat, no bus_valid, done 1 cycle after cfg handshake.
- Abort: cmd_abort asserted in the same cycle as the bus_ready of beat 1 of 4.
  - Next cycle: IDLE, all valids 0, no done.
  - A new command accepted 1 cycle later runs normally from its own base tags.
- Reset mid-run: rst low during RDB of beat 2.
  - All outputs 0 at once, cmd_ready=1; stays idle after rst returns high.
  - A following identical command reproduces the basic-run result.
- Aliased tags: tagA=tagB=0x020, strides 1, count=2 → two memory reads per beat, d0_OUT==d1_OUT each beat.
